// File: rtl/freelist_ckpt_ctrl_pkg.sv
// ============================================================================
// Module      : freelist_ckpt_ctrl_pkg
// Description : Shared rename constants and checkpoint FSM state encoding.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package freelist_ckpt_ctrl_pkg;

  localparam int CKPT_DEPTH         = 8;
  localparam int CKPT_TAG_W         = 3;
  localparam int SIZE_FREE_LIST_LOG = 7;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } ckpt_state_e;

endpackage

`default_nettype wire

// File: rtl/freelist_ckpt_ctrl_if.sv
// ============================================================================
// Module      : freelist_ckpt_ctrl_if
// Description : Allocate / resolve / recovery bundle for the checkpoint controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

interface freelist_ckpt_ctrl_if #(
  parameter int TAG_W  = 3,
  parameter int HEAD_W = 7
);

  logic              stall_i;
  logic              recoverFlag_i;
  logic              ckptReq_i;
  logic [HEAD_W-1:0] freeListHead_i;
  logic              ckptGrant_o;
  logic [TAG_W-1:0]  ckptTag_o;
  logic              ckptFull_o;
  logic              resolveValid_i;
  logic [TAG_W-1:0]  resolveTag_i;
  logic              mispredict_i;
  logic              ctrlVerified_o;
  logic              flagRecoverEX_o;
  logic [HEAD_W-1:0] freeListHeadCp_o;
  logic [TAG_W:0]    ckptCount_o;

  modport master (
    output stall_i, recoverFlag_i, ckptReq_i, freeListHead_i,
    output resolveValid_i, resolveTag_i, mispredict_i,
    input  ckptGrant_o, ckptTag_o, ckptFull_o,
    input  ctrlVerified_o, flagRecoverEX_o, freeListHeadCp_o, ckptCount_o
  );

  modport slave (
    input  stall_i, recoverFlag_i, ckptReq_i, freeListHead_i,
    input  resolveValid_i, resolveTag_i, mispredict_i,
    output ckptGrant_o, ckptTag_o, ckptFull_o,
    output ctrlVerified_o, flagRecoverEX_o, freeListHeadCp_o, ckptCount_o
  );

endinterface

`default_nettype wire

// File: rtl/freelist_ckpt_ctrl_ckpt_snapshot_rf.sv
// ============================================================================
// Module      : ckpt_snapshot_rf
// Description : DEPTH x HEAD_W snapshot storage, one write port, async read.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module ckpt_snapshot_rf #(
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 3,
  parameter int HEAD_W = 7
) (
  input  wire logic              clk,
  input  wire logic              we_i,
  input  wire logic [TAG_W-1:0]  waddr_i,
  input  wire logic [HEAD_W-1:0] wdata_i,
  input  wire logic [TAG_W-1:0]  raddr_i,
  output logic      [HEAD_W-1:0] rdata_o
);

  logic [HEAD_W-1:0] mem_q [DEPTH];

  // Contents are only read for live slots, so no reset is needed.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/freelist_ckpt_ctrl.sv
// ============================================================================
// Module      : freelist_ckpt_ctrl
// Description : Branch-checkpoint allocator and mispredict recovery for the free list.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module freelist_ckpt_ctrl
  import freelist_ckpt_ctrl_pkg::*;
#(
  parameter int DEPTH  = CKPT_DEPTH,
  parameter int TAG_W  = CKPT_TAG_W,
  parameter int HEAD_W = SIZE_FREE_LIST_LOG
) (
  input wire logic            clk,
  input wire logic            reset,
  freelist_ckpt_ctrl_if.slave bus
);

  ckpt_state_e       state_q, state_d;
  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]    count_q, count_d;
  logic [DEPTH-1:0]  live_q, live_d, resolved_q, resolved_d;
  logic              pulse_q, pulse_d;
  logic [HEAD_W-1:0] cp_q, cp_d;

  logic              w_full, w_grant, w_release, w_mispredict, w_correct;
  logic [HEAD_W-1:0] w_snap_rd;
  logic [TAG_W-1:0]  w_tag_dist, w_head_rel;

  assign w_full       = (count_q == (TAG_W+1)'(DEPTH));
  assign w_grant      = bus.ckptReq_i & ~bus.stall_i & ~w_full & (state_q == RUN)
                      & ~(bus.resolveValid_i & bus.mispredict_i) & reset;
  assign w_release    = (count_q != '0) & resolved_q[head_q] & live_q[head_q];
  assign w_mispredict = bus.resolveValid_i & bus.mispredict_i & live_q[bus.resolveTag_i]
                      & (state_q == RUN);
  assign w_correct    = bus.resolveValid_i & ~bus.mispredict_i & live_q[bus.resolveTag_i]
                      & (state_q == RUN);
  assign w_tag_dist   = bus.resolveTag_i - head_q;
  assign w_head_rel   = head_q + TAG_W'(w_release);

  ckpt_snapshot_rf #(
    .DEPTH  (DEPTH),
    .TAG_W  (TAG_W),
    .HEAD_W (HEAD_W)
  ) u_snap (
    .clk     (clk),
    .we_i    (w_grant),
    .waddr_i (tail_q),
    .wdata_i (bus.freeListHead_i),
    .raddr_i (bus.resolveTag_i),
    .rdata_o (w_snap_rd)
  );

  always_comb begin
    state_d    = RUN;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    live_d     = live_q;
    resolved_d = resolved_q;
    pulse_d    = 1'b0;
    cp_d       = cp_q;
    if (bus.recoverFlag_i) begin
      head_d     = '0;
      tail_d     = '0;
      count_d    = '0;
      live_d     = '0;
      resolved_d = '0;
    end else if (w_mispredict) begin
      state_d = RECOVER;
      pulse_d = 1'b1;
      cp_d    = w_snap_rd;
      if (w_release) begin
        live_d[head_q]     = 1'b0;
        resolved_d[head_q] = 1'b0;
      end
      // Squash the mispredicted slot and everything younger, measured from head.
      for (int i = 0; i < DEPTH; i++) begin
        if ((TAG_W'(i) - head_q) >= w_tag_dist) begin
          live_d[i]     = 1'b0;
          resolved_d[i] = 1'b0;
        end
      end
      head_d  = w_head_rel;
      tail_d  = bus.resolveTag_i;
      count_d = {1'b0, bus.resolveTag_i - w_head_rel};
    end else begin
      if (w_correct) begin
        resolved_d[bus.resolveTag_i] = 1'b1;
      end
      if (w_release) begin
        live_d[head_q]     = 1'b0;
        resolved_d[head_q] = 1'b0;
        head_d             = head_q + 1'b1;
      end
      if (w_grant) begin
        live_d[tail_q]     = 1'b1;
        resolved_d[tail_q] = 1'b0;
        tail_d             = tail_q + 1'b1;
      end
      count_d = count_q + (TAG_W+1)'(w_grant) - (TAG_W+1)'(w_release);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      live_q     <= '0;
      resolved_q <= '0;
      pulse_q    <= 1'b0;
      cp_q       <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      live_q     <= live_d;
      resolved_q <= resolved_d;
      pulse_q    <= pulse_d;
      cp_q       <= cp_d;
    end
  end

  assign bus.ckptGrant_o      = w_grant;
  assign bus.ckptTag_o        = tail_q & {TAG_W{reset}};
  assign bus.ckptFull_o       = w_full & reset;
  assign bus.ctrlVerified_o   = pulse_q;
  assign bus.flagRecoverEX_o  = pulse_q;
  assign bus.freeListHeadCp_o = cp_q;
  assign bus.ckptCount_o      = count_q;

endmodule

`default_nettype wire

// File: tb/tb_freelist_ckpt_ctrl.sv
// ============================================================================
// Module      : tb_freelist_ckpt_ctrl
// Description : Directed self-checking bench for the checkpoint controller.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_freelist_ckpt_ctrl;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  freelist_ckpt_ctrl_if #(.TAG_W(3), .HEAD_W(7)) bus ();

  freelist_ckpt_ctrl #(.DEPTH(8), .TAG_W(3), .HEAD_W(7)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall_i        = 1'b0;
    bus.recoverFlag_i  = 1'b0;
    bus.ckptReq_i      = 1'b0;
    bus.freeListHead_i = '0;
    bus.resolveValid_i = 1'b0;
    bus.resolveTag_i   = '0;
    bus.mispredict_i   = 1'b0;
  endtask

  task automatic flush();
    idle();
    bus.recoverFlag_i = 1'b1;
    tick();
    bus.recoverFlag_i = 1'b0;
  endtask

  task automatic resolve(input int tag, input logic mis);
    idle();
    bus.resolveValid_i = 1'b1;
    bus.resolveTag_i   = 3'(tag);
    bus.mispredict_i   = mis;
  endtask

  // Starts from an empty, head=tail=0 controller; fills all 8 slots with heads 10..17.
  task automatic alloc_full();
    for (int i = 0; i < 8; i++) begin
      idle();
      bus.ckptReq_i      = 1'b1;
      bus.freeListHead_i = 7'(10 + i);
      #1;
      chk_eq("alloc_grant", 32'(bus.ckptGrant_o), 32'd1);
      chk_eq("alloc_tag", 32'(bus.ckptTag_o), 32'(i));
      tick();
    end
    idle();
    chk_eq("full_count", 32'(bus.ckptCount_o), 32'd8);
    chk_eq("full_flag", 32'(bus.ckptFull_o), 32'd1);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    idle();
    reset = 1'b0;

    // Reset
    tick();
    tick();
    bus.ckptReq_i = 1'b1;
    #1;
    chk_eq("rst_grant", 32'(bus.ckptGrant_o), 32'd0);
    chk_eq("rst_tag", 32'(bus.ckptTag_o), 32'd0);
    chk_eq("rst_full", 32'(bus.ckptFull_o), 32'd0);
    chk_eq("rst_count", 32'(bus.ckptCount_o), 32'd0);
    chk_eq("rst_verified", 32'(bus.ctrlVerified_o), 32'd0);
    chk_eq("rst_recoverex", 32'(bus.flagRecoverEX_o), 32'd0);
    chk_eq("rst_headcp", 32'(bus.freeListHeadCp_o), 32'd0);
    idle();
    reset = 1'b1;
    tick();

    // Allocation to full, 9th request refused
    alloc_full();
    bus.ckptReq_i = 1'b1;
    #1;
    chk_eq("ninth_grant", 32'(bus.ckptGrant_o), 32'd0);
    tick();

    // Out-of-order correct resolves: 2, 0, 1
    resolve(2, 1'b0);
    tick();
    chk_eq("ooo_cnt_a", 32'(bus.ckptCount_o), 32'd8);
    resolve(0, 1'b0);
    tick();
    chk_eq("ooo_cnt_b", 32'(bus.ckptCount_o), 32'd8);
    resolve(1, 1'b0);
    bus.ckptReq_i = 1'b1;
    #1;
    chk_eq("full_rel_grant", 32'(bus.ckptGrant_o), 32'd0);
    tick();
    chk_eq("ooo_cnt_c", 32'(bus.ckptCount_o), 32'd7);
    idle();
    tick();
    chk_eq("ooo_cnt_d", 32'(bus.ckptCount_o), 32'd6);
    tick();
    chk_eq("ooo_cnt_e", 32'(bus.ckptCount_o), 32'd5);
    tick();
    chk_eq("ooo_cnt_f", 32'(bus.ckptCount_o), 32'd5);

    // Head must now be 3: mispredicting tag 3 leaves zero live checkpoints
    resolve(3, 1'b1);
    tick();
    idle();
    chk_eq("head3_pulse", 32'(bus.ctrlVerified_o), 32'd1);
    chk_eq("head3_cp", 32'(bus.freeListHeadCp_o), 32'd13);
    chk_eq("head3_count", 32'(bus.ckptCount_o), 32'd0);
    tick();
    chk_eq("head3_pulse_end", 32'(bus.ctrlVerified_o), 32'd0);

    // Mispredict tag 5 with a simultaneous request
    flush();
    alloc_full();
    resolve(5, 1'b1);
    bus.ckptReq_i      = 1'b1;
    bus.freeListHead_i = 7'd99;
    #1;
    chk_eq("mis_req_grant", 32'(bus.ckptGrant_o), 32'd0);
    tick();
    bus.resolveValid_i = 1'b0;
    bus.mispredict_i   = 1'b0;
    chk_eq("mis_verified", 32'(bus.ctrlVerified_o), 32'd1);
    chk_eq("mis_recoverex", 32'(bus.flagRecoverEX_o), 32'd1);
    chk_eq("mis_cp", 32'(bus.freeListHeadCp_o), 32'd15);
    chk_eq("mis_count", 32'(bus.ckptCount_o), 32'd5);
    chk_eq("recover_grant", 32'(bus.ckptGrant_o), 32'd0);
    tick();
    chk_eq("mis_pulse_end", 32'(bus.ctrlVerified_o), 32'd0);
    chk_eq("post_mis_grant", 32'(bus.ckptGrant_o), 32'd1);
    chk_eq("post_mis_tag", 32'(bus.ckptTag_o), 32'd5);
    tick();
    idle();
    chk_eq("post_mis_count", 32'(bus.ckptCount_o), 32'd6);

    // Mispredict followed by a commit-time flush
    resolve(2, 1'b1);
    tick();
    idle();
    bus.recoverFlag_i = 1'b1;
    tick();
    idle();
    chk_eq("flush_pulse", 32'(bus.ctrlVerified_o), 32'd0);
    chk_eq("flush_count", 32'(bus.ckptCount_o), 32'd0);
    chk_eq("flush_full", 32'(bus.ckptFull_o), 32'd0);

    // Resolve naming a dead tag is ignored
    resolve(4, 1'b1);
    tick();
    idle();
    chk_eq("dead_pulse", 32'(bus.ctrlVerified_o), 32'd0);
    chk_eq("dead_count", 32'(bus.ckptCount_o), 32'd0);

    // Ten allocate/verify pairs wrap the tag 7 -> 0
    for (int i = 0; i < 10; i++) begin
      idle();
      bus.ckptReq_i      = 1'b1;
      bus.freeListHead_i = 7'(40 + i);
      #1;
      chk_eq("wrap_grant", 32'(bus.ckptGrant_o), 32'd1);
      chk_eq("wrap_tag", 32'(bus.ckptTag_o), 32'(i % 8));
      tick();
      chk_eq("wrap_cnt_alloc", 32'(bus.ckptCount_o), 32'd1);
      resolve(i % 8, 1'b0);
      tick();
      chk_eq("wrap_cnt_res", 32'(bus.ckptCount_o), 32'd1);
      idle();
      tick();
      chk_eq("wrap_cnt_rel", 32'(bus.ckptCount_o), 32'd0);
    end

    // Reset during RECOVER drops the pulse and clears state
    idle();
    bus.ckptReq_i      = 1'b1;
    bus.freeListHead_i = 7'd77;
    tick();
    resolve(2, 1'b1);
    tick();
    idle();
    chk_eq("midrec_pulse_on", 32'(bus.ctrlVerified_o), 32'd1);
    chk_eq("midrec_cp", 32'(bus.freeListHeadCp_o), 32'd77);
    reset = 1'b0;
    tick();
    chk_eq("midrec_pulse_off", 32'(bus.ctrlVerified_o), 32'd0);
    chk_eq("midrec_count", 32'(bus.ckptCount_o), 32'd0);
    chk_eq("midrec_cp_clr", 32'(bus.freeListHeadCp_o), 32'd0);
    reset = 1'b1;
    bus.ckptReq_i = 1'b1;
    #1;
    chk_eq("midrec_tag", 32'(bus.ckptTag_o), 32'd0);
    tick();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
